// File: rtl/timer_pkg.sv
// timer_pkg: FSM encoding and default sizing shared by the timer scheduler blocks.
package timer_pkg;
  typedef enum logic [2:0] {IDLE, SELECT, WAIT_LOW, WAIT_HIGH, COUNT, DONE} state_t;
  localparam int DEF_WIDTH = 11;
  localparam int DEF_TIMEOUT = 1000;
endpackage

// File: rtl/rr_select.sv
// rr_select: first set mask bit at or after ptr, wrapping; N must be a power of two.
module rr_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 found
);
  localparam int W = $clog2(N);
  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[ptr + W'(i)]) begin
        idx = ptr + W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_scheduler.sv
// timer_scheduler: round-robin high-pulse width measurement over NCH channels.
module timer_scheduler import timer_pkg::*; #(
  parameter int NCH = 4,
  parameter int WIDTH = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         in,
  input  logic [NCH-1:0]         en,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] cur_ch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_ovf,
  output logic                   out_tmo
);
  localparam int CW = $clog2(NCH);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] ptr, pick;
  logic found, lvl, act, last_wait, sat;
  logic [WIDTH-1:0] width;
  logic [TW-1:0] wait_cnt;
  rr_select #(.N(NCH)) u_rr (
    .mask(en),
    .ptr(ptr),
    .idx(pick),
    .found(found)
  );
  assign lvl = in[cur_ch];
  assign act = en[cur_ch];
  assign busy = state != IDLE;
  assign last_wait = wait_cnt == TW'(TIMEOUT - 1);
  // A rising edge seen on the final allowed wait cycle still starts a count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cur_ch <= '0;
      wait_cnt <= '0;
      width <= '0;
      sat <= 1'b0;
      out_valid <= 1'b0;
      out_ch <= '0;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_tmo <= 1'b0;
    end else begin
      case (state)
        IDLE: state <= |en ? SELECT : IDLE;
        SELECT: begin
          cur_ch <= found ? pick : cur_ch;
          wait_cnt <= '0;
          state <= found ? WAIT_LOW : IDLE;
        end
        WAIT_LOW, WAIT_HIGH: begin
          if (!act) begin
            ptr <= cur_ch + CW'(1);
            state <= IDLE;
          end else if (state == WAIT_HIGH && lvl) begin
            width <= WIDTH'(1);
            sat <= 1'b0;
            state <= COUNT;
          end else if (last_wait) begin
            out_ch <= cur_ch;
            out_data <= '0;
            out_ovf <= 1'b0;
            out_tmo <= 1'b1;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
            state <= (state == WAIT_LOW && !lvl) ? WAIT_HIGH : state;
          end
        end
        COUNT: begin
          if (!act) begin
            ptr <= cur_ch + CW'(1);
            state <= IDLE;
          end else if (lvl) begin
            width <= &width ? width : width + WIDTH'(1);
            sat <= sat | &width;
          end else begin
            out_ch <= cur_ch;
            out_data <= width;
            out_ovf <= sat;
            out_tmo <= 1'b0;
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ptr <= cur_ch + CW'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_timer_scheduler.sv
// tb_timer_scheduler: directed and randomized checks against an event-level reference model.
module tb_timer_scheduler;
  localparam int TIMEOUT = 1000;
  localparam int MAXC = 3200;
  typedef struct {
    logic [1:0]  ch;
    logic [10:0] data;
    logic        ovf;
    logic        tmo;
    int          at;
  } res_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] pin = '0, en = '0;
  logic out_ready = 1'b0;
  logic busy, out_valid, out_ovf, out_tmo;
  logic [1:0] cur_ch, out_ch;
  logic [10:0] out_data;
  logic wave [4][MAXC];
  logic rdy [MAXC];
  logic [3:0] enw [MAXC];
  res_t obs_q[$], exp_q[$];
  int errors = 0, checks = 0;
  timer_scheduler #(.NCH(4), .WIDTH(11), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in(pin), .en(en), .busy(busy), .cur_ch(cur_ch),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_data(out_data), .out_ovf(out_ovf), .out_tmo(out_tmo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; pin = '0; en = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic clear(input logic [3:0] m);
    for (int k = 0; k < MAXC; k++) begin
      for (int i = 0; i < 4; i++) wave[i][k] = 1'b0;
      rdy[k] = 1'b1;
      enw[k] = m;
    end
  endtask
  task automatic pulse(input int ch, input int start, input int n);
    for (int k = start; k < start + n; k++) wave[ch][k] = 1'b1;
  endtask
  // Edge k sees wave/rdy/enw[k]; a result is accepted at edge k if valid was seen after edge k-1.
  task automatic run(input int len);
    res_t r;
    logic v;
    v = 1'b0;
    r = '{2'd0, 11'd0, 1'b0, 1'b0, 0};
    obs_q.delete();
    for (int k = 1; k <= len; k++) begin
      for (int i = 0; i < 4; i++) pin[i] = wave[i][k];
      en = enw[k];
      out_ready = rdy[k];
      if (v && rdy[k]) begin
        r.at = k;
        obs_q.push_back(r);
      end
      @(posedge clk);
      #1;
      v = out_valid; r.ch = out_ch; r.data = out_data; r.ovf = out_ovf; r.tmo = out_tmo;
    end
  endtask
  // Event timeline: IDLE sees en at edge e, selection at e+1, waiting starts at edge e+2.
  function automatic void model(input int len);
    int ptr, e, ch, e0, ef, er, ff, ed, n, acc;
    logic [3:0] m;
    res_t r;
    m = enw[1];
    ptr = 0;
    e = 1;
    exp_q.delete();
    while (m != 0) begin
      ch = -1;
      for (int i = 0; i < 4; i++) if (ch < 0 && m[(ptr + i) % 4]) ch = (ptr + i) % 4;
      e0 = e + 2;
      ef = e0;
      while (ef < e0 + TIMEOUT && ef <= len && wave[ch][ef]) ef++;
      er = ef + 1;
      while (er < e0 + TIMEOUT && er <= len && !wave[ch][er]) er++;
      if (er < e0 + TIMEOUT) begin
        if (er > len) break;
        ff = er + 1;
        while (ff <= len && wave[ch][ff]) ff++;
        if (ff > len) break;
        ed = ff; n = ff - er;
        r.tmo = 1'b0;
      end else begin
        ed = e0 + TIMEOUT - 1; n = 0;
        r.tmo = 1'b1;
      end
      acc = ed + 1;
      while (acc <= len && !rdy[acc]) acc++;
      if (acc > len) break;
      r.ch = 2'(ch);
      r.data = n > 2047 ? 11'd2047 : 11'(n);
      r.ovf = n > 2047;
      r.at = acc;
      exp_q.push_back(r);
      ptr = (ch + 1) % 4;
      e = acc + 1;
    end
  endfunction
  task automatic cmp_model(input string tag, input int len);
    model(len);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_%0d_ch", tag, i), obs_q[i].ch, exp_q[i].ch);
      chk($sformatf("%s_%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
      chk($sformatf("%s_%0d_ovf", tag, i), obs_q[i].ovf, exp_q[i].ovf);
      chk($sformatf("%s_%0d_tmo", tag, i), obs_q[i].tmo, exp_q[i].tmo);
      chk($sformatf("%s_%0d_at", tag, i), obs_q[i].at, exp_q[i].at);
    end
  endtask
  task automatic chk_first(input string tag, input int idx, input logic [1:0] ch,
                           input logic [10:0] data, input logic ovf, input logic tmo);
    chk({tag, "_avail"}, obs_q.size() > idx, 1);
    if (obs_q.size() > idx)
      chk({tag, "_fields"}, {obs_q[idx].ch, obs_q[idx].data, obs_q[idx].ovf, obs_q[idx].tmo},
          {ch, data, ovf, tmo});
  endtask
  initial begin
    int lvl, t, seg;
    logic [3:0] m;
    @(posedge clk);
    #1;
    chk("reset_state", {busy, cur_ch, out_valid, out_ch, out_data, out_ovf, out_tmo}, 0);
    // single 5-cycle pulse on ch0
    clear(4'b0001); pulse(0, 10, 5);
    do_reset(); run(40);
    cmp_model("basic", 40);
    chk_first("basic_res", 0, 2'd0, 11'd5, 1'b0, 1'b0);
    if (obs_q.size() > 0) chk("basic_at", obs_q[0].at, 16);
    // round-robin across all channels
    clear(4'b1111);
    for (int s = 5; s < 190; s += 12) for (int i = 0; i < 4; i++) pulse(i, s + i, 3);
    do_reset(); run(200);
    cmp_model("rr", 200);
    chk("rr_avail", obs_q.size() >= 5, 1);
    for (int k = 0; k < 5 && k < obs_q.size(); k++) chk($sformatf("rr_order_%0d", k), obs_q[k].ch, k % 4);
    // pulse in progress at selection is skipped
    clear(4'b0010); pulse(1, 1, 19); pulse(1, 25, 3);
    do_reset(); run(40);
    cmp_model("skip", 40);
    chk_first("skip_res", 0, 2'd1, 11'd3, 1'b0, 1'b0);
    // saturation
    clear(4'b0001); pulse(0, 10, 2100);
    do_reset(); run(2130);
    cmp_model("sat", 2130);
    chk_first("sat_res", 0, 2'd0, 11'd2047, 1'b1, 1'b0);
    // stuck-low timeout
    clear(4'b0100);
    do_reset(); run(1010);
    cmp_model("tmo", 1010);
    chk_first("tmo_res", 0, 2'd2, 11'd0, 1'b0, 1'b1);
    if (obs_q.size() > 0) chk("tmo_at", obs_q[0].at, 1003);
    // enable drop aborts and advances the pointer past ch0
    clear(4'b0011); enw[8] = 4'b0010; pulse(1, 15, 4);
    do_reset(); run(40);
    chk("abort_count", obs_q.size(), 1);
    chk_first("abort_res", 0, 2'd1, 11'd4, 1'b0, 1'b0);
    // backpressure then reset while a result is held
    clear(4'b0010); pulse(1, 8, 7);
    for (int k = 0; k < MAXC; k++) rdy[k] = 1'b0;
    do_reset(); run(30);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_%0d", k), {out_valid, out_ch, out_data, out_ovf, out_tmo},
          {1'b1, 2'd1, 11'd7, 1'b0, 1'b0});
    end
    rst = 1'b1;
    #1;
    chk("rst_done", {busy, cur_ch, out_valid, out_ch, out_data, out_ovf, out_tmo}, 0);
    // reset mid-count
    clear(4'b0100); pulse(2, 10, 50);
    do_reset(); run(20);
    chk("mid_count_busy", {busy, cur_ch}, {1'b1, 2'd2});
    rst = 1'b1;
    #1;
    chk("rst_count", {busy, cur_ch, out_valid, out_ch, out_data, out_ovf, out_tmo}, 0);
    // randomized traffic with random backpressure
    for (int it = 0; it < 3; it++) begin
      m = 4'($urandom_range(1, 15));
      clear(m);
      for (int i = 0; i < 4; i++) begin
        lvl = $urandom_range(0, 1);
        t = 1;
        while (t < MAXC) begin
          seg = ($urandom_range(0, 60) == 0) ? $urandom_range(200, 1100) : $urandom_range(1, 10);
          for (int k = t; k < t + seg && k < MAXC; k++) wave[i][k] = lvl[0];
          t += seg;
          lvl = 1 - lvl;
        end
      end
      for (int k = 0; k < MAXC; k++) rdy[k] = $urandom_range(0, 3) != 0;
      do_reset(); run(3000);
      cmp_model($sformatf("rnd%0d", it), 3000);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
